// File: rtl/round_robin_pkg.sv
// Shared constants and the quantum-extract helper for the round_robin arbiter.
// Used by round_robin and rr_next_pick; see round_robin.sv for ROUND_ROBIN_WEIGHT_EN.
package round_robin_pkg;

    localparam int NUM_Q = 4;
    localparam int QW    = 3;
    localparam int ID_W  = 2;

    // Quantum of queue idx, packed as request[QW*idx +: QW].
    function automatic logic [QW-1:0] get_quantum(
        input logic [NUM_Q*QW-1:0] req,
        input logic [ID_W-1:0]     idx
    );
        return req[int'(idx)*QW +: QW];
    endfunction

endpackage

// File: rtl/rr_next_pick.sv
// Circular search for the next eligible queue after the current id.
// The current id itself is checked last, so a sole eligible queue keeps the grant.
module rr_next_pick
    import round_robin_pkg::*;
(
    input  logic [NUM_Q-1:0] eligible,
    input  logic [ID_W-1:0]  id,
    output logic [ID_W-1:0]  pick,
    output logic             found
);

    // Walk from the farthest candidate back to id+1 so the closest eligible one wins.
    always_comb begin
        pick  = id;
        found = 1'b0;
        for (int k = NUM_Q; k >= 1; k--) begin
            if (eligible[id + ID_W'(k)]) begin
                pick  = id + ID_W'(k);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/round_robin.sv
// Round-robin arbiter over four queues with a registered grant index.
// Define ROUND_ROBIN_WEIGHT_EN to honour the 3-bit quanta; otherwise every enabled queue gets one cycle.
module round_robin
    import round_robin_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_Q*QW-1:0] request,
    input  logic [NUM_Q-1:0]    empty,
    output logic [ID_W-1:0]     id
);

    logic [NUM_Q-1:0] eligible;
    logic [ID_W-1:0]  pick;
    logic             found;

    // A queue competes only when it has data and a nonzero quantum.
    always_comb begin
        eligible = '0;
        for (int i = 0; i < NUM_Q; i++) begin
            eligible[i] = !empty[i] && (get_quantum(request, ID_W'(i)) != '0);
        end
    end

    rr_next_pick u_next_pick (
        .eligible (eligible),
        .id       (id),
        .pick     (pick),
        .found    (found)
    );

`ifdef ROUND_ROBIN_WEIGHT_EN
    logic [QW-1:0] cnt;
    logic [QW-1:0] quantum;
    logic          hold;

    assign quantum = get_quantum(request, id);
    // Widened compare so cnt+1 cannot wrap against a quantum of 7.
    assign hold    = eligible[id] && (({1'b0, cnt} + 4'd1) < {1'b0, quantum});

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            id  <= '0;
            cnt <= '0;
        end else if (hold) begin
            cnt <= cnt + 3'd1;
        end else begin
            cnt <= '0;
            if (found) begin
                id <= pick;
            end
        end
    end
`else
    // Without weighting every grant expires after one cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            id <= '0;
        end else if (found) begin
            id <= pick;
        end
    end
`endif

endmodule

// File: tb/tb_round_robin.sv
// Testbench for round_robin: directed table, hand-written corner sequences and a random run
// checked against a queue-level arbitration model. Honours ROUND_ROBIN_WEIGHT_EN like the RTL.
module tb_round_robin;

    logic        clk;
    logic        reset;
    logic [11:0] request;
    logic [3:0]  empty;
    logic [1:0]  id;

    int checks = 0;
    int errors = 0;

    int m_id     = 0;
    int m_served = 0;

    typedef struct {
        bit          rst;
        logic [11:0] req;
        logic [3:0]  emp;
        logic [1:0]  exp;
        string       name;
    } vec_t;

    vec_t vecs[$];

    round_robin dut (
        .clk     (clk),
        .reset   (reset),
        .request (request),
        .empty   (empty),
        .id      (id)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic applyStimulus(input logic [11:0] r, input logic [3:0] e);
        request = r;
        empty   = e;
    endtask

    task automatic checkOutput(input string name, input logic [1:0] exp);
        checks++;
        if (id !== exp) begin
            errors++;
            $display("[TB] FAIL %s: id=%0d expected %0d at %0t", name, id, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        @(negedge clk);
        reset = 1'b1;
        #1;
        checkOutput("async_reset", 2'd0);
        @(negedge clk);
        reset    = 1'b0;
        m_id     = 0;
        m_served = 0;
    endtask

    // Queue-level arbitration: serve the current queue up to its quantum, else take the next one in circle.
    task automatic modelEdge(input logic [11:0] r, input logic [3:0] e);
        int  q[4];
        bit  el[4];
        bit  done;
        for (int i = 0; i < 4; i++) begin
            q[i] = int'((r >> (3 * i)) & 12'd7);
`ifndef ROUND_ROBIN_WEIGHT_EN
            if (q[i] != 0) q[i] = 1;
`endif
            el[i] = (e[i] == 1'b0) && (q[i] != 0);
        end
        if (el[m_id] && (m_served + 1 < q[m_id])) begin
            m_served++;
        end else begin
            m_served = 0;
            done     = 1'b0;
            for (int k = 1; k <= 4; k++) begin
                if (!done && el[(m_id + k) % 4]) begin
                    m_id = (m_id + k) % 4;
                    done = 1'b1;
                end
            end
        end
    endtask

    task automatic addVec(input bit rst, input logic [11:0] r, input logic [3:0] e,
                          input logic [1:0] exp, input string name);
        vec_t v;
        v.rst  = rst;
        v.req  = r;
        v.emp  = e;
        v.exp  = exp;
        v.name = name;
        vecs.push_back(v);
    endtask

    initial begin
        logic [1:0]  rot[8];
        logic [1:0]  rel[9];
        logic [11:0] rreq;
        logic [3:0]  remp;

`ifdef ROUND_ROBIN_WEIGHT_EN
        rot = '{2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd0, 2'd1};
        rel = '{2'd2, 2'd2, 2'd3, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd3};
`else
        rot = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        rel = '{2'd2, 2'd3, 2'd3, 2'd2, 2'd3, 2'd2, 2'd3, 2'd2, 2'd3};
`endif

        // Rotation with quanta q3..q0 = 1,2,3,1.
        for (int i = 0; i < 8; i++)
            addVec(i == 0, {3'd1, 3'd2, 3'd3, 3'd1}, 4'b0000, rot[i], "rotation");
        // Skip empty queues 0 and 2, then disable queue 1 as well.
        addVec(1'b1, 12'h249, 4'b0101, 2'd1, "skip");
        addVec(1'b0, 12'h249, 4'b0101, 2'd3, "skip");
        addVec(1'b0, 12'h249, 4'b0101, 2'd1, "skip");
        addVec(1'b0, 12'h249, 4'b0101, 2'd3, "skip");
        addVec(1'b0, 12'h241, 4'b0101, 2'd3, "skip_sole");
        addVec(1'b0, 12'h241, 4'b0101, 2'd3, "skip_sole");
        // Idle holds the last grant, then queue 0 wakes up.
        addVec(1'b0, 12'h249, 4'b1111, 2'd3, "idle");
        addVec(1'b0, 12'h249, 4'b1111, 2'd3, "idle");
        addVec(1'b0, 12'h249, 4'b1110, 2'd0, "idle_wake");

        reset   = 1'b1;
        request = 12'($urandom);
        empty   = 4'($urandom);
        #1;
        checkOutput("reset_initial", 2'd0);
        @(negedge clk);
        reset = 1'b0;

        foreach (vecs[i]) begin
            if (vecs[i].rst) doReset();
            applyStimulus(vecs[i].req, vecs[i].emp);
            tick();
            checkOutput(vecs[i].name, vecs[i].exp);
        end

        // Early release: queue 2 with quantum 5 goes empty after two grant cycles.
        doReset();
        for (int i = 0; i < 9; i++) begin
            applyStimulus(12'h340, (i == 2) ? 4'b0100 : 4'b0000);
            tick();
            checkOutput("early_release", rel[i]);
        end

        // Reset mid-quantum must discard the served count.
        doReset();
        applyStimulus(12'h00B, 4'b0000);
        tick();
`ifdef ROUND_ROBIN_WEIGHT_EN
        checkOutput("midreset_pre", 2'd0);
`else
        checkOutput("midreset_pre", 2'd1);
`endif
        doReset();
        applyStimulus(12'h00B, 4'b0000);
        tick();
`ifdef ROUND_ROBIN_WEIGHT_EN
        checkOutput("midreset_a", 2'd0);
        tick();
        checkOutput("midreset_b", 2'd0);
        tick();
        checkOutput("midreset_c", 2'd1);
`else
        checkOutput("midreset_a", 2'd1);
        tick();
        checkOutput("midreset_b", 2'd0);
        tick();
        checkOutput("midreset_c", 2'd1);
`endif

        // Random traffic against the model.
        doReset();
        rreq = 12'($urandom);
        remp = 4'b0000;
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 59) == 0) doReset();
            if ($urandom_range(0, 7) == 0) rreq = 12'($urandom);
            if ($urandom_range(0, 2) == 0) remp = 4'($urandom & $urandom);
            applyStimulus(rreq, remp);
            modelEdge(rreq, remp);
            tick();
            checkOutput("random", 2'(m_id));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/round_robin.md
ROUND_ROBIN -- requirements
Module: round_robin

Interface
REQ-001 Parameters: none; widths are fixed by package constants NUM_Q=4, QW=3, ID_W=2.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 request  input  12  per-queue quantum; request[3i+2:3i] = quantum of queue i (i=0..3), unsigned, 0 = queue disabled.
REQ-005 empty  input  4  empty[i]=1 means queue i has no data.
REQ-006 id  output  2  index of queue currently granted; registered, driven directly from a flop.

Function
REQ-007 eligible[i] SHALL be (empty[i]==0) and (quantum[i]!=0), evaluated combinationally from current inputs.
REQ-008 Internal state SHALL be id (2 bits) and a grant counter cnt (3 bits) counting cycles already served on id.
REQ-009 At each rising edge, if eligible[id] and cnt+1 < quantum[id]: id holds and cnt increments.
REQ-010 Otherwise (quantum expired or id not eligible), next id SHALL be the first eligible queue in circular order id+1, id+2, id+3, id; cnt SHALL clear to 0.
REQ-011 If no queue is eligible, id SHALL hold its value and cnt SHALL clear to 0 (idle).
REQ-012 Sole eligible queue: id stays on it and cnt restarts at 0 each time the quantum expires.
REQ-013 Quantum 1: queue granted for exactly one cycle before rotating; quantum 7: up to seven consecutive cycles.
REQ-014 A queue becoming empty mid-quantum SHALL lose the grant at the next edge (no wasted cycles beyond one).
REQ-015 Wrap-around: search from id=3 continues at 0; arithmetic on id is modulo 4.
REQ-016 Latency: input change affects id at the next rising edge; no combinational path from inputs to id.

Reset
REQ-017 While reset is high, id SHALL be 0 and cnt SHALL be 0, asynchronously, irrespective of clk.
REQ-018 After reset deasserts, the first edge SHALL apply REQ-009/REQ-010 from id=0, cnt=0 (queue 0 is granted first if eligible).
REQ-019 Reset asserted mid-quantum SHALL discard the counter; no history is kept.

Configuration
REQ-020 Macro ROUND_ROBIN_WEIGHT_EN defined: weighted round robin per REQ-009 using the 3-bit quanta.
REQ-021 Macro not defined: every nonzero quantum SHALL be treated as 1 (plain round robin, rotate every cycle), zero still disables the queue; cnt is unused and may be removed.

Structure
REQ-022 Package round_robin_pkg SHALL hold NUM_Q, QW, ID_W and a quantum-extract helper.
REQ-023 One sub-module rr_next_pick SHALL compute the next eligible index given eligible[3:0] and the current id, plus a found flag.
REQ-024 round_robin SHALL contain only the eligible logic, counter and registers and instantiate rr_next_pick once.

Verification
REQ-025 Reset: reset=1 with random request/empty -> id=0 immediately, before any clk edge.
REQ-026 Weighted rotation (macro on): request={3'd1,3'd2,3'd3,3'd1} (q3..q0), empty=4'b0000 -> id sequence after reset 0,1,1,1,2,2,3,0,1,...
REQ-027 Plain rotation (macro off): same stimulus -> id sequence 0,1,2,3,0,1,... one cycle each.
REQ-028 Skip: empty=4'b0101, all quanta 1 -> id alternates 1,3,1,3; request[5:3]=0 additionally -> id stays 3.
REQ-029 Early release: id=2 with quantum 5, empty[2] rises after 2 grant cycles -> next edge id=3 (if eligible), cnt=0.
REQ-030 Idle: empty=4'b1111 -> id holds last value; then empty=4'b1110 -> id=0 on next edge.
